// File: rtl/pkt_gen_task_executor.sv
// pkt_gen_task_executor: consumes {flow, size} tasks and emits one Avalon-ST
// packet per task (header beat, then byte-pattern payload beats) on a 64-bit bus.
// Optional feature macro: PKT_GEN_SEQ_NUM_EN (per-flow 32-bit sequence numbers).
module pkt_gen_task_executor #(
  parameter int FLOW_CNT       = 16,
  parameter int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT),
  parameter int MIN_PKT_SIZE   = 64,
  parameter int MAX_PKT_SIZE   = 1518
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [FLOW_CNT_WIDTH-1:0] task_flow_num_i,
  input  logic [15:0]               task_pkt_size_i,
  input  logic                      task_valid_i,
  output logic                      task_ready_o,
  output logic [63:0]               pkt_data_o,
  output logic                      pkt_startofpacket_o,
  output logic                      pkt_endofpacket_o,
  output logic [2:0]                pkt_empty_o,
  output logic                      pkt_valid_o,
  input  logic                      pkt_ready_i,
  output logic                      size_err_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [FLOW_CNT_WIDTH-1:0] flow_q, flow_d;
  logic [15:0]               size_q, size_d;
  logic [15:0]               beat_q, beat_d;
  logic                      size_err_q, size_err_d;

  logic [15:0] last_beat;
  logic        is_eop;
  logic        beat_xfer;
  logic        eop_xfer;
  logic        task_accept;
  logic [31:0] seq_cur;

  function automatic logic [15:0] clamp_size(input logic [15:0] sz);
    if (sz < 16'(MIN_PKT_SIZE))      return 16'(MIN_PKT_SIZE);
    else if (sz > 16'(MAX_PKT_SIZE)) return 16'(MAX_PKT_SIZE);
    else                             return sz;
  endfunction

  function automatic logic size_out_of_range(input logic [15:0] sz);
    return (sz < 16'(MIN_PKT_SIZE)) || (sz > 16'(MAX_PKT_SIZE));
  endfunction

  // Payload beat n: every byte is n[7:0]; on the last beat bytes beyond S are zeroed.
  function automatic logic [63:0] payload_beat(input logic [15:0] n, input logic [15:0] s,
                                               input logic last);
    logic [63:0] d;
    logic [3:0]  nbytes;
    nbytes = (s[2:0] == 3'd0) ? 4'd8 : {1'b0, s[2:0]};
    d = '0;
    for (int i = 0; i < 8; i++) begin
      d[63-8*i -: 8] = (!last || (4'(i) < nbytes)) ? n[7:0] : 8'h00;
    end
    return d;
  endfunction

  // Beat index of the eop beat is ceil(S/8)-1; widened so S=65535 cannot overflow.
  assign last_beat   = 16'(({1'b0, size_q} + 17'd7) >> 3) - 16'd1;
  assign pkt_valid_o = (state_q != ST_IDLE);
  assign is_eop      = pkt_valid_o && (beat_q == last_beat);
  assign beat_xfer   = pkt_valid_o && pkt_ready_i;
  assign eop_xfer    = beat_xfer && is_eop;
  // A new task can be taken while idle or on the very cycle the eop beat leaves.
  assign task_ready_o = !rst_i && ((state_q == ST_IDLE) || eop_xfer);
  assign task_accept  = task_valid_i && task_ready_o;
  assign size_err_o   = size_err_q;

`ifdef PKT_GEN_SEQ_NUM_EN
  logic [31:0] seq_q [FLOW_CNT];
  logic [31:0] seq_d [FLOW_CNT];

  assign seq_cur = seq_q[flow_q];

  // Bump the flow's counter when its header (sop) beat is taken by the sink.
  always_comb begin
    seq_d = seq_q;
    if ((state_q == ST_HEADER) && pkt_ready_i) seq_d[flow_q] = seq_q[flow_q] + 32'd1;
  end

  // Sequence counter storage, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FLOW_CNT; i++) seq_q[i] <= 32'd0;
    end else begin
      seq_q <= seq_d;
    end
  end
`else
  assign seq_cur = 32'h0;
`endif

  // Output beat formatting from the registered packet context; all zero when idle.
  always_comb begin
    pkt_data_o          = '0;
    pkt_startofpacket_o = 1'b0;
    pkt_endofpacket_o   = is_eop;
    pkt_empty_o         = is_eop ? (3'd0 - size_q[2:0]) : 3'd0;
    if (state_q == ST_HEADER) begin
      pkt_data_o          = {size_q, 16'(flow_q), seq_cur};
      pkt_startofpacket_o = 1'b1;
    end else if (state_q == ST_PAYLOAD) begin
      pkt_data_o = payload_beat(beat_q, size_q, is_eop);
    end
  end

  // Next-state: accept wins (back-to-back), else retire on eop, else advance beat.
  always_comb begin
    state_d    = state_q;
    flow_d     = flow_q;
    size_d     = size_q;
    beat_d     = beat_q;
    size_err_d = size_err_q;
    if (task_accept) begin
      state_d = ST_HEADER;
      flow_d  = task_flow_num_i;
      size_d  = clamp_size(task_pkt_size_i);
      beat_d  = 16'd0;
      if (size_out_of_range(task_pkt_size_i)) size_err_d = 1'b1;
    end else if (eop_xfer) begin
      state_d = ST_IDLE;
    end else if (beat_xfer) begin
      state_d = ST_PAYLOAD;
      beat_d  = beat_q + 16'd1;
    end
  end

  // Control state is reset; packet context registers only load, gated by state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_err_q <= size_err_d;
    end
    flow_q <= flow_d;
    size_q <= size_d;
    beat_q <= beat_d;
  end

endmodule

// File: doc/pkt_gen_task_executor.md
# pkt_gen_task_executor

Consumer end of the packet-generator task interface. Accepts `{flow number, packet size}` tasks from the task FIFO with a valid/ready handshake. For each task it emits one complete packet on a 64-bit Avalon-ST source: a header beat carrying size, flow and sequence number, then pattern payload beats. It sits between the task FIFO and the MAC/TX-side streaming logic.

## Interface
Parameters:
- `FLOW_CNT`, 16: number of flows.
- `FLOW_CNT_WIDTH`, `(FLOW_CNT==1) ? 1 : $clog2(FLOW_CNT)`: internal; do not override.
- `MIN_PKT_SIZE`, 64: smallest emitted packet, bytes; must be ≥ 8.
- `MAX_PKT_SIZE`, 1518: largest emitted packet, bytes; must be ≤ 65535.

Ports (clock and reset first):
- `clk_i`  in  1  single clock; every register is on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `task_flow_num_i`  in  `FLOW_CNT_WIDTH`  flow of the offered task.
- `task_pkt_size_i`  in  16  requested packet size, bytes.
- `task_valid_i`  in  1  task offered.
- `task_ready_o`  out  1  task accepted when `task_valid_i && task_ready_o`.
- `pkt_data_o`  out  64  packet data; first byte in [63:56].
- `pkt_startofpacket_o`  out  1  first beat.
- `pkt_endofpacket_o`  out  1  last beat.
- `pkt_empty_o`  out  3  unused bytes on the eop beat; 0 on all other beats.
- `pkt_valid_o`  out  1  beat valid.
- `pkt_ready_i`  in  1  sink ready; a beat transfers when `pkt_valid_o && pkt_ready_i`.
- `size_err_o`  out  1  sticky; set when any accepted task needed clamping.

## Operation
- FSM states: IDLE, HEADER, PAYLOAD.
  - IDLE → HEADER on task accept.
  - HEADER → PAYLOAD when the header beat transfers and beats remain.
  - HEADER or PAYLOAD → IDLE when the eop beat transfers and no task is accepted in the same cycle.
  - eop beat transfers and a task is accepted in the same cycle → HEADER. This gives back-to-back packets.
- `task_ready_o` = !rst_i && (state==IDLE || (pkt_valid_o && pkt_ready_i && pkt_endofpacket_o)). It is combinational from `pkt_ready_i`.
- Size clamping on accept:
  - S = `task_pkt_size_i` clamped to [MIN_PKT_SIZE, MAX_PKT_SIZE].
  - Any clamp sets `size_err_o`.
  - Flow and S are latched at accept.
- Beat count B = ceil(S/8); a 16-bit beat index n runs 0..B-1.
- Header beat (n=0):
  - [63:48] = S.
  - [47:32] = flow number, zero-extended.
  - [31:0] = sequence number (see Configuration).
- Payload beat n ≥ 1: every byte = n[7:0]. On the eop beat, bytes past S are 8'h00.
- Eop beat:
  - `pkt_endofpacket_o` is set on n = B-1.
  - `pkt_empty_o` = (8 - S%8) % 8.
  - S=64 → B=8, empty=0.
  - S=65 → B=9, empty=7.
- Avalon-ST rules:
  - `pkt_valid_o` is high in HEADER and PAYLOAD and low in IDLE.
  - While valid && !ready, data, sop, eop and empty hold stable.
  - `pkt_valid_o` never drops mid-packet.
- If S ≤ 8 (possible only with MIN_PKT_SIZE = 8), the header beat carries both sop and eop.

## Timing
- Task accepted in cycle T → sop beat is presented in T+1.
- With `pkt_ready_i` held at 1, a packet occupies exactly B cycles.
- Back-to-back tasks produce zero idle cycles between eop and the next sop.
- Single-beat or wait-stated eop with a new task: the new sop appears the cycle after the eop transfers.
- Reset values:
  - State is IDLE.
  - `pkt_valid_o`, `pkt_startofpacket_o`, `pkt_endofpacket_o`, `size_err_o` are 0.
  - `pkt_data_o` and `pkt_empty_o` are 0.
  - `task_ready_o` is 0 while `rst_i` is high and 1 the first cycle after.
- Reset asserted mid-packet: the packet is abandoned with no eop, and the next sop starts a fresh packet. Downstream must tolerate this.

## Configuration
- Macro `PKT_GEN_SEQ_NUM_EN`.
- Defined:
  - A per-flow 32-bit sequence counter array (FLOW_CNT entries) is compiled in, reset to 0.
  - Header [31:0] = current counter of the packet's flow.
  - The counter increments when that packet's sop beat transfers and wraps 32'hFFFF_FFFF → 0.
- Not defined: no counter storage; header [31:0] = 32'h0.

## Test plan
- Flow 3, size 64, `pkt_ready_i`=1:
  - 8 beats, sop at beat 0, eop at beat 7, empty=0.
  - Header = {16'd64, 16'd3, 32'd0}.
  - Beat 5 data = 64'h0505_0505_0505_0505.
- Size 70:
  - 9 beats, eop empty=2.
  - Last beat = 64'h0808_0808_0808_0000.
- Sizes 10 and 4000:
  - Emitted as 64 and 1518 bytes.
  - `size_err_o` rises after the first task and stays 1.
- Random `pkt_ready_i` backpressure at 50%: outputs stable while stalled; no beat lost or duplicated.
- Two tasks queued, ready=1: second sop immediately follows first eop, no gap.
- With `PKT_GEN_SEQ_NUM_EN`:
  - Three flow-2 packets carry seq 0, 1, 2.
  - An interleaved flow-5 packet carries seq 0.
  - `rst_i` mid-packet: next packet on flow 2 carries seq 0.
